// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder and its RAM array.
//   WORD_W   : data word width
//   CNT_W    : width of the wait-state counter (WAIT_CYCLES fits in 0..15)
//   state_t  : responder FSM encoding (IDLE = 0, WAIT = 1, RESP = 2)
//   addr_err : misaligned / out-of-range test for a byte address
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // The limit is 33 bits wide so DEPTH_WORDS*4 never wraps and the full
   // 32-bit address is compared, e.g. 0xFFFF_FFFC is out of range rather
   // than aliasing onto the last word.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input logic [32:0] limit);
      return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous RAM, DEPTH_WORDS x WORD_W, read-first. No reset on
// the storage so it maps onto block RAM.
//   clk   : rising-edge clock
//   we    : write enable for this cycle
//   idx   : word index (read and write)
//   wdata : write data
//   rdata : registered read data, mem[idx] as of before the edge
// -----------------------------------------------------------------------------
module dmem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[idx] <= wdata;
      end
      r_rdata <= r_mem[idx];
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Handshaked data-memory responder with a fixed number of wait states. Takes
// one load/store at a time, performs it after WAIT_CYCLES extra cycles, and
// holds a single response until the requester takes it.
//
// Handshake (both channels): a transfer happens on a rising edge where
// valid && ready are both 1. The requester may change or drop req_* freely
// while req_ready = 0. rsp_valid/rsp_rdata/rsp_err stay stable from the edge
// rsp_valid rises until the edge where rsp_ready is sampled high.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (req_ready depends on state only)
//   req_we              : 1 = store, 0 = load
//   req_addr, req_wdata : byte address, store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data; 0 for stores and errors
//   rsp_err             : misaligned or out-of-range access
//   dbg_state           : current FSM state (IDLE=0, WAIT=1, RESP=2)
// -----------------------------------------------------------------------------
module dmem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        dbg_state
);

   localparam int               IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0]      ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(WAIT_CYCLES);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic              r_rsp_load;   // response carries RAM read data

   logic              w_err;
   logic              w_access;
   logic              w_ram_we;
   logic [IDX_W-1:0]  w_idx;
   logic [WORD_W-1:0] w_ram_rdata;

   assign w_err    = addr_err(r_addr, ADDR_LIMIT);
   assign w_idx    = r_addr[IDX_W+1:2];
   assign w_access = (r_state == WAIT) && (r_cnt == '0);
   // Bad accesses never write; the state term also keeps a store that is
   // discarded by reset out of the array.
   assign w_ram_we = w_access && r_we && !w_err;

   // The array re-reads r_addr every cycle. r_addr only changes on accept,
   // so the read data registered on the WAIT->RESP edge stays valid for the
   // whole RESP state.
   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (w_ram_we),
      .idx   (w_idx),
      .wdata (r_wdata),
      .rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_load  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_cnt   <= WAIT_INIT;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_load  <= !r_we && !w_err;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_load  <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Forced low while reset is held, so nothing is accepted during reset.
   assign req_ready = !reset && (r_state == IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_load ? w_ram_rdata : '0;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share one clock: dut 0 (1024 words, 2 wait states) and
// dut 1 (16 words, 0 wait states). A table of directed vectors, reset
// sequences and randomized traffic are compared against a word-array model.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int D0_DEPTH = 1024;
   localparam int D0_WAIT  = 2;
   localparam int D1_DEPTH = 16;
   localparam int D1_WAIT  = 0;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_we;
   logic [1:0]       rsp_ready;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;

   logic        req_ready_0, req_ready_1;
   logic        rsp_valid_0, rsp_valid_1;
   logic        rsp_err_0,   rsp_err_1;
   logic [31:0] rsp_rdata_0, rsp_rdata_1;
   logic [1:0]  dbg_0,       dbg_1;

   logic [1:0]       req_ready;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_err;
   logic [1:0][31:0] rsp_rdata;
   logic [1:0][1:0]  dbg_state;

   assign req_ready = {req_ready_1, req_ready_0};
   assign rsp_valid = {rsp_valid_1, rsp_valid_0};
   assign rsp_err   = {rsp_err_1,   rsp_err_0};
   assign rsp_rdata = {rsp_rdata_1, rsp_rdata_0};
   assign dbg_state = {dbg_1,       dbg_0};

   dmem_responder #(.DEPTH_WORDS(D0_DEPTH), .WAIT_CYCLES(D0_WAIT)) u_dut0 (
      .clk       (clk),
      .reset     (reset[0]),
      .req_valid (req_valid[0]),
      .req_ready (req_ready_0),
      .req_we    (req_we[0]),
      .req_addr  (req_addr[0]),
      .req_wdata (req_wdata[0]),
      .rsp_valid (rsp_valid_0),
      .rsp_ready (rsp_ready[0]),
      .rsp_rdata (rsp_rdata_0),
      .rsp_err   (rsp_err_0),
      .dbg_state (dbg_0)
   );

   dmem_responder #(.DEPTH_WORDS(D1_DEPTH), .WAIT_CYCLES(D1_WAIT)) u_dut1 (
      .clk       (clk),
      .reset     (reset[1]),
      .req_valid (req_valid[1]),
      .req_ready (req_ready_1),
      .req_we    (req_we[1]),
      .req_addr  (req_addr[1]),
      .req_wdata (req_wdata[1]),
      .rsp_valid (rsp_valid_1),
      .rsp_ready (rsp_ready[1]),
      .rsp_rdata (rsp_rdata_1),
      .rsp_err   (rsp_err_1),
      .dbg_state (dbg_1)
   );

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];
   logic        err_q[$];
   logic [31:0] mdl [2][16];

   function automatic int depth_of(input int d);
      return (d == 0) ? D0_DEPTH : D1_DEPTH;
   endfunction

   function automatic int wait_of(input int d);
      return (d == 0) ? D0_WAIT : D1_WAIT;
   endfunction

   function automatic logic exp_err(input int d, input logic [31:0] a);
      longint unsigned la;
      la = 64'(a);
      return ((la % 4) != 0) || (la >= longint'(depth_of(d)) * 4);
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   // ---------------- driver ----------------
   // One full transaction; expected response is taken from exp_q/err_q.
   // hold = number of cycles rsp_ready stays low after rsp_valid rises.
   task automatic txn(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold);
      logic [31:0] exp_d, got_d;
      logic        exp_e, got_e;
      int          n;
      logic        seen;
      exp_d = exp_q.pop_front();
      exp_e = err_q.pop_front();
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      rsp_ready[d] = (hold == 0);
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) begin
         check1("accept_timeout", 1'b0, 1'b1);
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Busy: present junk that must be ignored.
      req_we[d]    = 1'($urandom_range(0, 1));
      req_addr[d]  = $urandom & 32'h3C;
      req_wdata[d] = $urandom;
      n = 0;
      seen = 1'b0;
      while (n < 40 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         seen = rsp_valid[d];
      end
      req_valid[d] = 1'b0;
      if (!seen) begin
         check1("rsp_timeout", 1'b0, 1'b1);
         return;
      end
      check("latency", 32'(n), 32'(wait_of(d) + 1));
      got_d = rsp_rdata[d];
      got_e = rsp_err[d];
      check("rdata", got_d, exp_d);
      check1("err", got_e, exp_e);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         check1("hold_valid", rsp_valid[d], 1'b1);
         check("hold_rdata", rsp_rdata[d], got_d);
         check1("hold_err", rsp_err[d], got_e);
         check1("hold_req_ready", req_ready[d], 1'b0);
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      check1("rsp_done", rsp_valid[d], 1'b0);
      check1("ready_back", req_ready[d], 1'b1);
      rsp_ready[d] = 1'b0;
   endtask

   task automatic expect_rsp(input logic [31:0] d_exp, input logic e_exp);
      exp_q.push_back(d_exp);
      err_q.push_back(e_exp);
   endtask

   task automatic check_reset_outputs(input string tag, input int d);
      check1({tag, "_req_ready"}, req_ready[d], 1'b0);
      check1({tag, "_rsp_valid"}, rsp_valid[d], 1'b0);
      check1({tag, "_rsp_err"},   rsp_err[d],   1'b0);
      check({tag, "_rsp_rdata"},  rsp_rdata[d], 32'h0);
      check({tag, "_state"},      32'(dbg_state[d]), 32'h0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, wd;
      logic        we, e;
      int          r, w, hold, n, bad;

      reset     = 2'b11;
      req_valid = '0;
      req_we    = '0;
      rsp_ready = '0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset state while reset is held.
      repeat (2) @(negedge clk);
      check_reset_outputs("rst0", 0);
      check_reset_outputs("rst1", 1);
      reset = 2'b00;
      #1;
      check1("ready_after_rst0", req_ready[0], 1'b1);
      check1("ready_after_rst1", req_ready[1], 1'b1);

      vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 0, 32'h0,          1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,          1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF,  1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF,  1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0,         0, 32'h0,          1'b1};
      vecs[5]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 0, 32'h0,          1'b1};
      vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         0, 32'hA5A5_A5A5,  1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'h0F0F_0F0F, 0, 32'h0,          1'b0};
      vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2, 32'h0,          1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         0, 32'h0F0F_0F0F,  1'b0};
      vecs[10] = '{1'b0, 32'h0000_1004, 32'h0,         0, 32'h0,          1'b1};
      vecs[11] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 0, 32'h0,          1'b0};
      vecs[12] = '{1'b1, 32'h0000_0021, 32'h9999_9999, 1, 32'h0,          1'b1};
      vecs[13] = '{1'b0, 32'h0000_0020, 32'h0,         0, 32'h1111_1111,  1'b0};

      for (int i = 0; i < 14; i++) begin
         expect_rsp(vecs[i].exp_rdata, vecs[i].exp_err);
         txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold);
      end

      // Reset pulse in the middle of a held load response.
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h10;
      rsp_ready[0] = 1'b0;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      n = 0;
      while (!rsp_valid[0] && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check1("probe_rsp_valid", rsp_valid[0], 1'b1);
      check("probe_rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
      #2;
      reset[0] = 1'b1;
      #1;
      check_reset_outputs("midrst", 0);
      @(negedge clk);
      reset[0] = 1'b0;
      #1;
      check1("midrst_ready_back", req_ready[0], 1'b1);

      // Reset while a store to 0x20 is still in WAIT.
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'h2222_2222;
      check1("waitrst_ready", req_ready[0], 1'b1);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      check("waitrst_in_wait", 32'(dbg_state[0]), 32'h1);
      #2;
      reset[0] = 1'b1;
      @(negedge clk);
      reset[0] = 1'b0;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (rsp_valid[0]) bad++;
      end
      check("waitrst_no_rsp", 32'(bad), 32'h0);
      expect_rsp(32'h1111_1111, 1'b0);
      txn(0, 1'b0, 32'h20, 32'h0, 0);

      // Zero wait states: back-to-back loads with rsp_ready high, last word,
      // and the first out-of-range address.
      expect_rsp(32'h0, 1'b0);
      txn(1, 1'b1, 32'h3C, 32'h5A5A_0001, 0);
      expect_rsp(32'h5A5A_0001, 1'b0);
      txn(1, 1'b0, 32'h3C, 32'h0, 0);
      expect_rsp(32'h5A5A_0001, 1'b0);
      txn(1, 1'b0, 32'h3C, 32'h0, 0);
      expect_rsp(32'h0, 1'b1);
      txn(1, 1'b1, 32'h40, 32'hBAD0_BAD0, 0);
      expect_rsp(32'h0, 1'b1);
      txn(1, 1'b0, 32'h40, 32'h0, 0);

      // Randomized traffic against the word-array model.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) begin
            mdl[d][i] = $urandom;
            expect_rsp(32'h0, 1'b0);
            txn(d, 1'b1, 32'(i) * 4, mdl[d][i], 0);
         end
         for (int i = 0; i < 40; i++) begin
            r    = int'($urandom_range(0, 8));
            w    = int'($urandom_range(0, 15));
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            hold = int'($urandom_range(0, 3));
            if (r <= 5)      a = 32'(w) * 4;
            else if (r == 6) a = 32'(w) * 4 + $urandom_range(1, 3);
            else if (r == 7) a = 32'(depth_of(d)) * 4 + $urandom_range(0, 63) * 4;
            else             a = $urandom | 32'h8000_0000;
            e = exp_err(d, a);
            if (e) begin
               expect_rsp(32'h0, 1'b1);
            end else if (we) begin
               mdl[d][a / 4] = wd;
               expect_rsp(32'h0, 1'b0);
            end else begin
               expect_rsp(mdl[d][a / 4], 1'b0);
            end
            txn(d, we, a, wd, hold);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
